// File: rtl/spi_access_arbiter.sv
// Two-port arbiter in front of a single AFE SPI read/write engine. Port 0 (streaming)
// has fixed priority, port 1 (host/config) is protected by a starvation counter.
module spi_access_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 24,
    parameter int TIMEOUT_CYC = 4096,
    parameter int STARVE_MAX  = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] spi_addr_r,
    output logic              spi_rd_begin,
    output logic [ADDR_W-1:0] spi_addr_w,
    output logic [DATA_W-1:0] spi_wdata,
    output logic              spi_wr_begin,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rdata,

    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [1:0]        state_dbg
);

    // Requester handshake: raise req with rw/addr/wdata stable and hold it until done.
    // req is only sampled in IDLE; dropping it later does not cancel the transaction.
    // done is a single-cycle pulse and err/rdata are valid in that same cycle.

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic              rd_begin_q, rd_begin_d;
    logic              wr_begin_q, wr_begin_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              timeout_err_q, timeout_err_d;

    logic              pick1;
    logic              finish;
    logic              timed_out;
    logic [DATA_W-1:0] rsp;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wd_d          = wd_q;
        starve_d      = req1 ? starve_q : '0;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        busy_d        = busy_q;
        rd_begin_d    = 1'b0;
        wr_begin_d    = 1'b0;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        // A timeout set in the same cycle as err_clr overrides the clear below.
        timeout_err_d = timeout_err_q & ~err_clr;
        pick1         = req1 & (~req0 | (starve_q == SC_MAX));
        finish        = 1'b0;
        timed_out     = 1'b0;
        rsp           = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d    = pick1;
                    rw_d       = pick1 ? rw1 : rw0;
                    addr_d     = pick1 ? addr1 : addr0;
                    wdata_d    = pick1 ? wdata1 : wdata0;
                    rd_begin_d = pick1 ? ~rw1 : ~rw0;
                    wr_begin_d = pick1 ? rw1 : rw0;
                    gnt0_d     = ~pick1;
                    gnt1_d     = pick1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                    if (pick1) begin
                        starve_d = '0;
                    end else if (req1) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // spi_done on the final watchdog cycle still counts as success.
                if (spi_done) begin
                    finish = 1'b1;
                    rsp    = rw_q ? '0 : spi_rdata;
                end else if (wd_q == WD_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (finish) begin
                    state_d = DONE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    err0_d  = ~owner_q & timed_out;
                    err1_d  = owner_q & timed_out;
                    if (owner_q) begin
                        rdata1_d = rsp;
                    end else begin
                        rdata0_d = rsp;
                    end
                    if (timed_out) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wd_q          <= '0;
            starve_q      <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            busy_q        <= 1'b0;
            rd_begin_q    <= 1'b0;
            wr_begin_q    <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wd_q          <= wd_d;
            starve_q      <= starve_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            busy_q        <= busy_d;
            rd_begin_q    <= rd_begin_d;
            wr_begin_q    <= wr_begin_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign err0         = err0_q;
    assign err1         = err1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign spi_addr_r   = addr_q;
    assign spi_addr_w   = addr_q;
    assign spi_wdata    = wdata_q;
    assign spi_rd_begin = rd_begin_q;
    assign spi_wr_begin = wr_begin_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_spi_access_arbiter.sv
// Directed bench for spi_access_arbiter: latency, priority, starvation relief,
// watchdog timeout, sticky error flag and asynchronous reset mid-transaction.
module tb_spi_access_arbiter;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 24;
    localparam int TIMEOUT_CYC = 16;
    localparam int STARVE_MAX  = 8;

    logic              clk;
    logic              reset;
    logic              req0, rw0, req1, rw1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, done0, done1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] spi_addr_r, spi_addr_w;
    logic [DATA_W-1:0] spi_wdata, spi_rdata;
    logic              spi_rd_begin, spi_wr_begin, spi_done;
    logic              busy, timeout_err, err_clr;
    logic [1:0]        state_dbg;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    spi_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .spi_addr_r(spi_addr_r), .spi_rd_begin(spi_rd_begin),
        .spi_addr_w(spi_addr_w), .spi_wdata(spi_wdata), .spi_wr_begin(spi_wr_begin),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr), .state_dbg(state_dbg)
    );

    // Clock / global bound
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI engine model: called at the begin sample; pulses spi_done lat cycles later
    // and returns at the sample where done should be visible.
    task automatic serve(input int lat, input logic [DATA_W-1:0] data);
        repeat (lat) @(negedge clk);
        spi_done  = 1'b1;
        spi_rdata = data;
        @(negedge clk);
        spi_done  = 1'b0;
        spi_rdata = DATA_W'($urandom_range(0, 24'hFFFFFF));
    endtask

    task automatic wait_begin(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (spi_rd_begin || spi_wr_begin) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        bit got;
        bit seen_done;
        bit seen_busy;

        reset = 1'b1;
        req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
        spi_done = 1'b0; spi_rdata = '0; err_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {gnt0, gnt1, done0, done1, err0, err1, spi_rd_begin, spi_wr_begin,
                           busy, timeout_err, state_dbg}, 32'h0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_spi_bus", {spi_addr_r, spi_addr_w, spi_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1. Port 1 read, engine answers 5 cycles after begin
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h2A; wdata1 = DATA_W'($urandom_range(0, 24'hFFFFFF));
        @(negedge clk);
        check("t1_rd_begin", {spi_rd_begin, spi_wr_begin, gnt1, gnt0, busy}, 5'b10101);
        check("t1_addr_r", spi_addr_r, 8'h2A);
        check("t1_state_issue", state_dbg, 1);
        @(negedge clk);
        check("t1_begin_one_cycle", spi_rd_begin, 0);
        check("t1_state_wait", state_dbg, 2);
        serve(4, 24'h00ABCD);
        check("t1_done1", {done1, done0, err1, gnt1}, 4'b1001);
        check("t1_rdata1", rdata1, 24'h00ABCD);
        req1 = 1'b0;
        @(negedge clk);
        check("t1_after", {done1, gnt1, busy}, 0);
        check("t1_rdata1_held", rdata1, 24'h00ABCD);

        // 2. Port 0 write; stray spi_done in ISSUE and late input changes are ignored
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h00; wdata0 = 24'h000008;
        @(negedge clk);
        check("t2_wr_begin", {spi_wr_begin, spi_rd_begin, gnt0, gnt1}, 4'b1010);
        check("t2_addr_w", spi_addr_w, 8'h00);
        check("t2_wdata", spi_wdata, 24'h000008);
        addr0 = 8'h55; wdata0 = 24'hFFFFFF; spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        @(negedge clk);
        check("t2_stray_done_ignored", {done0, state_dbg}, {1'b0, 2'd2});
        serve(1, 24'hDEAD01);
        check("t2_done0", {done0, err0, done1}, 3'b100);
        check("t2_rdata0", rdata0, 0);
        check("t2_latched", {spi_addr_w, spi_wdata}, {8'h00, 24'h000008});
        req0 = 1'b0;
        @(negedge clk);

        // 3. Simultaneous requests: port 0 first, port 1 begins at M+3
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h20;
        @(negedge clk);
        check("t3_first_owner", {gnt0, gnt1, spi_rd_begin}, 3'b101);
        check("t3_first_addr", spi_addr_r, 8'h10);
        serve(2, 24'h111111);
        check("t3_done0", {done0, done1}, 2'b10);
        check("t3_rdata0", rdata0, 24'h111111);
        req0 = 1'b0;
        @(negedge clk);
        check("t3_idle_gap", {spi_rd_begin, state_dbg}, 3'b000);
        @(negedge clk);
        check("t3_second_begin", {spi_rd_begin, gnt1, gnt0}, 3'b110);
        check("t3_second_addr", spi_addr_r, 8'h20);
        serve(2, 24'h222222);
        check("t3_done1", {done1, err1}, 2'b10);
        check("t3_rdata1", rdata1, 24'h222222);
        req1 = 1'b0;
        @(negedge clk);

        // 4. Starvation relief: 8 port-0 grants, then one port-1 grant, repeating
        for (int k = 0; k < 18; k++) exp_q.push_back((k % 9 == 8) ? 32'd1 : 32'd0);
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h02;
        for (int k = 0; k < 18; k++) begin
            wait_begin(ok);
            check("t4_begin_seen", ok, 1);
            if (!ok) break;
            got = gnt1;
            check("t4_owner", got, exp_q.pop_front());
            serve(1, DATA_W'(k));
            check("t4_done", got ? done1 : done0, 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // 5. Watchdog timeout, sticky flag, clear, and set-wins-over-clear
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h33;
        @(negedge clk);
        check("t5a_begin", spi_rd_begin, 1);
        seen_done = 1'b0;
        repeat (TIMEOUT_CYC) begin
            @(negedge clk);
            if (done0 || done1) seen_done = 1'b1;
        end
        check("t5a_no_early_done", seen_done, 0);
        @(negedge clk);
        check("t5a_timeout_done", {done1, err1, timeout_err}, 3'b111);
        check("t5a_rdata1_zero", rdata1, 0);
        req1 = 1'b0;
        @(negedge clk);
        check("t5a_sticky_idle", timeout_err, 1);
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h34;
        @(negedge clk);
        check("t5b_begin", spi_rd_begin, 1);
        serve(3, 24'h5A5A5A);
        check("t5b_good_done", {done1, err1, timeout_err}, 3'b101);
        check("t5b_rdata1", rdata1, 24'h5A5A5A);
        req1 = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5c_cleared", timeout_err, 0);
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h35;
        @(negedge clk);
        check("t5d_begin", spi_rd_begin, 1);
        repeat (TIMEOUT_CYC) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5d_set_wins", {done0, err0, timeout_err}, 3'b111);
        check("t5d_rdata0_zero", rdata0, 0);
        req0 = 1'b0;
        @(negedge clk);

        // 6. Reset in WAIT: outputs clear asynchronously, no done afterwards
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h44;
        @(negedge clk);
        check("t6_begin", spi_rd_begin, 1);
        repeat (2) @(negedge clk);
        check("t6_in_wait", {state_dbg, gnt0}, {2'd2, 1'b1});
        reset = 1'b1;
        #1;
        check("t6_async_ctrl", {gnt0, gnt1, done0, done1, busy, timeout_err, state_dbg}, 0);
        check("t6_async_data", {rdata1, spi_addr_r}, 0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        spi_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spi_done = 1'b0;
            if (done0 || done1) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("t6_no_done_after_reset", seen_done, 0);
        check("t6_idle_spi_done_ignored", seen_busy, 0);
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h77; wdata1 = 24'h123456;
        @(negedge clk);
        check("t6_new_wr_begin", {spi_wr_begin, gnt1}, 2'b11);
        check("t6_new_bus", {spi_addr_w, spi_wdata}, {8'h77, 24'h123456});
        serve(2, 24'h0ABCDE);
        check("t6_new_done", {done1, err1}, 2'b10);
        check("t6_new_rdata1", rdata1, 0);
        req1 = 1'b0;
        @(negedge clk);
        check("t6_final_idle", {busy, gnt1}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
